// File: rtl/t5_norm_shift_pkg.sv
// Shared widths and types for the two-stage normalising left shifter.
package t5_norm_shift_pkg;

    localparam int unsigned NORM_W  = 74;
    localparam int unsigned NORM_SW = 10;

    // Revision flags travelling with each data set.
    typedef struct packed {
        logic force_zero;
        logic lza_fix;
    } revi_t;

endpackage

// File: rtl/t5_norm_shift_lshift.sv
// Combinational W-bit logical left shifter; shifts of W or more yield zero.
module norm_lshift
    import t5_norm_shift_pkg::*;
#(
    parameter int unsigned W  = NORM_W,
    parameter int unsigned SW = NORM_SW
) (
    input  logic [W-1:0]  din,
    input  logic [SW-1:0] amt,
    output logic [W-1:0]  dout
);

    assign dout = din << amt;

endmodule

// File: rtl/t5_norm_shift.sv
// Two-stage normaliser: coarse byte shift, then fine shift plus optional one-bit
// LZA correction, with valid/ready flow control and full throughput.
module t5_norm_shift
    import t5_norm_shift_pkg::*;
#(
    parameter int unsigned W  = NORM_W,
    parameter int unsigned SW = NORM_SW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SW-1:0] sh_num,
    input  logic [1:0]    esh,
    input  logic [W-1:0]  p_reg,
    input  logic [1:0]    revi,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  norm,
    output logic [SW-1:0] sh_tot,
    output logic [1:0]    esh_o,
    output logic          zero
);

    localparam logic [SW-1:0] W_SH = SW'(W);

    logic          s1_valid;
    logic [W-1:0]  s1_data;
    logic [2:0]    s1_fine;
    logic [SW-1:0] s1_sh;
    logic          s1_over;
    logic [1:0]    s1_esh;
    revi_t         s1_revi;

    logic          load2;
    logic          over_in;
    logic [SW-1:0] sh_clamp;
    logic [SW-1:0] coarse_amt;
    logic [SW-1:0] fine_amt;
    logic [W-1:0]  coarse_data;
    logic [W-1:0]  fine_data;
    logic          corr;
    logic [W-1:0]  norm_next;
    logic [SW-1:0] tot_next;

    assign load2    = !out_valid || out_ready;
    assign in_ready = !s1_valid || load2;

    // Clamping to W keeps the coarse+fine split exact: 72 + 2 clears all bits.
    assign over_in    = sh_num >= W_SH;
    assign sh_clamp   = over_in ? W_SH : sh_num;
    assign coarse_amt = {sh_clamp[SW-1:3], 3'b000};
    assign fine_amt   = {{(SW-3){1'b0}}, s1_fine};

    norm_lshift #(.W(W), .SW(SW)) u_coarse (
        .din  (p_reg),
        .amt  (coarse_amt),
        .dout (coarse_data)
    );

    norm_lshift #(.W(W), .SW(SW)) u_fine (
        .din  (s1_data),
        .amt  (fine_amt),
        .dout (fine_data)
    );

    always_comb begin
        corr      = s1_revi.lza_fix && !s1_over && !fine_data[W-1];
        norm_next = corr ? {fine_data[W-2:0], 1'b0} : fine_data;
        tot_next  = s1_sh + {{(SW-1){1'b0}}, corr};
        if (s1_revi.force_zero) begin
            norm_next = '0;
            tot_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_fine  <= '0;
            s1_sh    <= '0;
            s1_over  <= 1'b0;
            s1_esh   <= '0;
            s1_revi  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= coarse_data;
                s1_fine <= sh_clamp[2:0];
                s1_sh   <= sh_clamp;
                s1_over <= over_in;
                s1_esh  <= esh;
                s1_revi <= revi_t'(revi);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            norm      <= '0;
            sh_tot    <= '0;
            esh_o     <= '0;
            zero      <= 1'b0;
        end else if (load2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                norm   <= norm_next;
                sh_tot <= tot_next;
                esh_o  <= s1_esh;
                zero   <= (norm_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_t5_norm_shift.sv
// Scoreboard bench for t5_norm_shift: directed vectors with hand-derived results.
module tb_t5_norm_shift;

    localparam int unsigned W  = 74;
    localparam int unsigned SW = 10;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] sh_num = '0;
    logic [1:0]    esh = '0;
    logic [W-1:0]  p_reg = '0;
    logic [1:0]    revi = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  norm;
    logic [SW-1:0] sh_tot;
    logic [1:0]    esh_o;
    logic          zero;

    t5_norm_shift #(.W(W), .SW(SW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sh_num    (sh_num),
        .esh       (esh),
        .p_reg     (p_reg),
        .revi      (revi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .norm      (norm),
        .sh_tot    (sh_tot),
        .esh_o     (esh_o),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  norm;
        logic [SW-1:0] sh_tot;
        logic [1:0]    esh;
        logic          zero;
    } exp_t;

    typedef struct {
        logic [W-1:0]  p;
        logic [SW-1:0] sh;
        logic [1:0]    esh;
        logic [1:0]    revi;
        exp_t          e;
    } vec_t;

    vec_t  vecs[$];
    exp_t  sb[$];
    int    pop_cyc[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    bp_idx = 0;
    logic [15:0] bp_pat = 16'b0110_0011_1000_1101;
    exp_t  mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] bitn(input int unsigned n);
        logic [W-1:0] one = 1;
        return one << n;
    endfunction

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void addv(input logic [W-1:0] p, input int unsigned sh, input logic [1:0] e,
                                 input logic [1:0] r, input logic [W-1:0] en, input int unsigned et,
                                 input logic ez);
        vec_t v;
        v.p = p;
        v.sh = SW'(sh);
        v.esh = e;
        v.revi = r;
        v.e.norm = en;
        v.e.sh_tot = SW'(et);
        v.e.esh = e;
        v.e.zero = ez;
        vecs.push_back(v);
    endfunction

    // Monitor: every valid output is compared to the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        if (rstn && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 128'(1), 128'(0));
            end else begin
                mon_e = sb[0];
                chk("norm", 128'(norm), 128'(mon_e.norm));
                chk("sh_tot", 128'(sh_tot), 128'(mon_e.sh_tot));
                chk("esh_o", 128'(esh_o), 128'(mon_e.esh));
                chk("zero", 128'(zero), 128'(mon_e.zero));
                if (out_ready) begin
                    void'(sb.pop_front());
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic send(input int idx, input int mode, output int tries);
        bit done = 1'b0;
        tries = 0;
        in_valid = 1'b1;
        p_reg    = vecs[idx].p;
        sh_num   = vecs[idx].sh;
        esh      = vecs[idx].esh;
        revi     = vecs[idx].revi;
        while (!done) begin
            @(negedge clk);
            tries++;
            if (in_ready) begin
                sb.push_back(vecs[idx].e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            case (mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = bp_pat[bp_idx];
                    bp_idx = (bp_idx + 1) % 16;
                end
                default: out_ready = 1'b0;
            endcase
            if (!done && tries > 60) begin
                chk("accept_timeout", 128'(0), 128'(1));
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic lat_check(input string tag);
        @(negedge clk);
        chk({tag, "_lat_cycle1"}, 128'(out_valid), 128'(0));
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_lat_cycle2"}, 128'(out_valid), 128'(1));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_norm"}, 128'(norm), 128'(0));
        chk({tag, "_sh_tot"}, 128'(sh_tot), 128'(0));
        chk({tag, "_esh_o"}, 128'(esh_o), 128'(0));
        chk({tag, "_zero"}, 128'(zero), 128'(0));
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int tries;
        int guard;
        logic [W-1:0] ones;
        logic [W-1:0] ff;
        ones = '1;
        ff = 'hFF;
        addv(bitn(16), 57, 2'd1, 2'b00, bitn(73), 57, 1'b0);
        addv(bitn(72), 0, 2'd2, 2'b01, bitn(73), 1, 1'b0);
        addv(bitn(72), 0, 2'd3, 2'b00, bitn(72), 0, 1'b0);
        addv(bitn(5) | bitn(0), 900, 2'd0, 2'b00, '0, 74, 1'b1);
        addv(ones, 3, 2'd1, 2'b10, '0, 0, 1'b1);
        addv('0, 5, 2'd2, 2'b00, '0, 5, 1'b1);
        addv('0, 5, 2'd3, 2'b01, '0, 6, 1'b1);
        addv(ff, 66, 2'd0, 2'b00, ff << 66, 66, 1'b0);
        addv(74'd9, 70, 2'd1, 2'b01, bitn(73) | bitn(70), 70, 1'b0);
        addv(bitn(60), 5, 2'd2, 2'b01, bitn(66), 6, 1'b0);
        addv(ones, 74, 2'd3, 2'b01, '0, 74, 1'b1);
        addv(74'd1, 73, 2'd0, 2'b00, bitn(73), 73, 1'b0);
        addv(74'd2, 73, 2'd1, 2'b01, '0, 74, 1'b1);
        addv(bitn(65) | bitn(1), 8, 2'd2, 2'b00, bitn(73) | bitn(9), 8, 1'b0);
        addv(ones, 1023, 2'd3, 2'b11, '0, 0, 1'b1);
        addv(bitn(73) | bitn(0), 0, 2'd0, 2'b01, bitn(73) | bitn(0), 0, 1'b0);

        // Reset behaviour
        #2 rstn = 1'b0;
        #3 chk_zero_outputs("in_reset");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 128'(in_ready), 128'(1));
        chk("out_valid_after_reset", 128'(out_valid), 128'(0));

        // Single transaction latency
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(0, 0, tries);
        lat_check("idle");
        repeat (2) @(posedge clk);
        #1 pop_cyc.delete();

        // Back-to-back stream at full throughput
        for (int i = 0; i < 4; i++) begin
            send(i, 0, tries);
            chk("stream_first_try", 128'(tries), 128'(1));
        end
        repeat (5) @(posedge clk);
        #1;
        chk("stream_result_count", 128'(pop_cyc.size()), 128'(4));
        if (pop_cyc.size() >= 4)
            chk("stream_consecutive", 128'(pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-4]), 128'(3));

        // Stall from empty: two accepts, then in_ready drops and the output holds
        out_ready = 1'b0;
        send(7, 2, tries);
        send(8, 2, tries);
        @(negedge clk);
        chk("stall_in_ready", 128'(in_ready), 128'(0));
        chk("stall_out_valid", 128'(out_valid), 128'(1));
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // All vectors twice under a fixed backpressure pattern
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < vecs.size(); i++)
                send(i, 1, tries);
        out_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #1 chk("bp_drain_empty", 128'(sb.size()), 128'(0));

        // Reset with both stages full
        out_ready = 1'b0;
        send(1, 2, tries);
        send(9, 2, tries);
        #2 rstn = 1'b0;
        #1 chk_zero_outputs("mid_reset");
        sb.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("in_ready_after_mid_reset", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(13, 0, tries);
        lat_check("post_reset");

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #1 chk("final_drain_empty", 128'(sb.size()), 128'(0));
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
